// File: rtl/pwm_capture.sv
// pwm_capture: measures the high time and rise-to-rise period of an asynchronous
// PWM input in clk cycles, emitting one duty/period pair per complete cycle.
//
// state     | meaning
// WAIT_RISE | idle; waiting for a rising edge to start a measurement
// MEAS_HIGH | counting the high phase since the last rise
// MEAS_LOW  | counting the low phase; next rise closes the period
module pwm_capture #(
  parameter int N = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         pwm_in,
  output logic [N-1:0] duty_out,
  output logic [N-1:0] period_out,
  output logic         valid,
  output logic         timeout
);

  typedef enum logic [1:0] {
    WAIT_RISE = 2'd0,
    MEAS_HIGH = 2'd1,
    MEAS_LOW  = 2'd2
  } state_t;

  localparam logic [N-1:0] CNT_MAX = '1;
  localparam logic [N-1:0] CNT_ONE = {{(N-1){1'b0}}, 1'b1};

  state_t       state_q, state_d;
  logic         s1, s2, s3;
  logic [2:0]   fill;
  logic         rise, fall;
  logic [N-1:0] cnt_q, cnt_d, cnt_inc;
  logic [N-1:0] hi_q, hi_d;
  logic [N-1:0] duty_d, period_d;
  logic         valid_d, timeout_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1   <= 1'b0;
      s2   <= 1'b0;
      s3   <= 1'b0;
      fill <= 3'b000;
    end else begin
      s1   <= pwm_in;
      s2   <= s1;
      s3   <= s2;
      fill <= {fill[1:0], 1'b1};
    end
  end

  // Edges count only once s2 and s3 both hold post-reset samples, so a pulse
  // already high when reset releases is not mistaken for a rise.
  assign rise    = fill[2] & s2 & ~s3;
  assign fall    = fill[2] & ~s2 & s3;
  assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    duty_d    = duty_out;
    period_d  = period_out;
    valid_d   = 1'b0;
    timeout_d = timeout;
    if (!en) begin
      state_d = WAIT_RISE;
    end else begin
      case (state_q)
        WAIT_RISE: begin
          if (rise) begin
            state_d = MEAS_HIGH;
            cnt_d   = CNT_ONE;
          end
        end
        MEAS_HIGH: begin
          cnt_d = cnt_inc;
          if (fall) begin
            state_d = MEAS_LOW;
            hi_d    = cnt_q;
          end else if (cnt_q == CNT_MAX) begin
            state_d   = WAIT_RISE;
            timeout_d = 1'b1;
          end
        end
        MEAS_LOW: begin
          cnt_d = cnt_inc;
          if (rise) begin
            state_d   = MEAS_HIGH;
            duty_d    = hi_q;
            period_d  = cnt_q;
            valid_d   = 1'b1;
            timeout_d = 1'b0;
            cnt_d     = CNT_ONE;
          end else if (cnt_q == CNT_MAX) begin
            state_d   = WAIT_RISE;
            timeout_d = 1'b1;
          end
        end
        default: state_d = WAIT_RISE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= WAIT_RISE;
      cnt_q      <= '0;
      hi_q       <= '0;
      duty_out   <= '0;
      period_out <= '0;
      valid      <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      hi_q       <= hi_d;
      duty_out   <= duty_d;
      period_out <= period_d;
      valid      <= valid_d;
      timeout    <= timeout_d;
    end
  end

endmodule
